// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between the fetch and data stages.
// The optional watchdog abort is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    starve_cnt_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_ack_q;
  logic          d_ack_q;

  logic          d_wins;
  logic          finish_d;
  logic [DW-1:0] fill_d;

  // Data has priority unless a waiting fetch has already been passed over STARVE_MAX times.
  assign d_wins = d_req && (!i_req || (starve_cnt_q < 4'(STARVE_MAX)));

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       err_q;
  logic       busy;

  assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign finish_d = m_ready || (wdog_q == 8'(TIMEOUT - 1));
  assign fill_d   = m_ready ? m_rdata : DW'(32'hDEADBEEF);
  assign err      = err_q;

  // The counter sits at zero outside BUSY, so every BUSY entry starts a fresh count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= busy ? wdog_q + 8'd1 : 8'd0;
      err_q  <= busy && finish_d && !m_ready;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign finish_d       = m_ready;
  assign fill_d         = m_rdata;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_wins) begin
            state_q   <= BUSY_D;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            if (i_req) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else if (i_req) begin
            state_q      <= BUSY_I;
            m_req_q      <= 1'b1;
            m_we_q       <= 1'b0;
            m_addr_q     <= i_addr;
            m_wdata_q    <= '0;
            starve_cnt_q <= 4'd0;
          end
        end
        BUSY_I: begin
          if (finish_d) begin
            state_q   <= DONE;
            m_req_q   <= 1'b0;
            i_ack_q   <= 1'b1;
            i_rdata_q <= fill_d;
          end
        end
        BUSY_D: begin
          if (finish_d) begin
            state_q <= DONE;
            m_req_q <= 1'b0;
            d_ack_q <= 1'b1;
            if (!m_we_q) begin
              d_rdata_q <= fill_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign stall_if  = i_req & ~i_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions checked against a transaction-level model
// of arbitration, starvation and read-data behaviour.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          stall_if;
  logic          stall_mem;
  logic          err;

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Transaction-level model state
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  int            starve = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one arbitration round starting in an IDLE cycle (entered at posedge+1).
  task automatic episode(input int waits, input logic [DW-1:0] rd, output bit won_d);
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    logic          exp_ia;
    won_d = d_req && (!i_req || starve < SMAX);
    if (won_d) begin
      ea = d_addr; ewe = d_we; ewd = d_wdata;
    end else begin
      ea = i_addr; ewe = 1'b0; ewd = '0;
    end
    m_ready = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    @(negedge clk);
    chk("idle_m_req", m_req, 1'b0);
    chk("idle_acks", {i_ack, d_ack}, 2'b00);
    chk("idle_stall_if", stall_if, i_req);
    chk("idle_stall_mem", stall_mem, d_req);
    if (won_d) begin
      if (i_req) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
    end else begin
      starve = 0;
    end
    for (int w = 0; w <= waits; w++) begin
      @(posedge clk); #1;
      m_ready = (w == waits);
      m_rdata = (w == waits) ? rd : $urandom;
      @(negedge clk);
      chk("busy_m_req", m_req, 1'b1);
      chk("busy_m_addr", m_addr, ea);
      chk("busy_m_we", m_we, ewe);
      chk("busy_m_wdata", m_wdata, ewd);
      chk("busy_acks", {i_ack, d_ack}, 2'b00);
      chk("busy_stall_if", stall_if, i_req);
      chk("busy_stall_mem", stall_mem, d_req);
    end
    @(posedge clk); #1;
    m_ready = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    exp_ia = !won_d;
    if (won_d) begin
      if (!ewe) exp_d_rdata = rd;
    end else begin
      exp_i_rdata = rd;
    end
    @(negedge clk);
    chk("done_i_ack", i_ack, exp_ia);
    chk("done_d_ack", d_ack, !exp_ia);
    chk("done_i_rdata", i_rdata, exp_i_rdata);
    chk("done_d_rdata", d_rdata, exp_d_rdata);
    chk("done_m_req", m_req, 1'b0);
    chk("done_stall_if", stall_if, i_req & ~exp_ia);
    chk("done_stall_mem", stall_mem, d_req & exp_ia);
    chk("done_err", err, 1'b0);
    chk("starve_cnt", dut.starve_cnt_q, 64'(starve));
    $display("txn %0d: %s addr=%08h we=%0d waits=%0d rdata=%08h",
             n_txn, won_d ? "data " : "fetch", ea, ewe, waits, rd);
    n_txn++;
    @(posedge clk); #1;
    m_ready = 1'b0;
    if (won_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bit won;

    // Reset state
    @(negedge clk);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_m_addr", m_addr, '0);
    chk("rst_m_wdata", m_wdata, '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_acks", {i_ack, d_ack}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_starve", dut.starve_cnt_q, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single fetch
    i_req = 1'b1; i_addr = 32'h40;
    episode(0, 32'h8C01_0004, won);

    // Simultaneous: data write wins, fetch follows in the next IDLE cycle
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55;
    episode(1, $urandom, won);
    episode(0, $urandom, won);

    // Starvation: fetch held while data keeps reissuing
    i_req = 1'b1; i_addr = 32'h200;
    for (int k = 0; k < 5; k++) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
      d_addr = 32'h1000 + 32'(k * 4); d_wdata = $urandom;
      episode($urandom_range(0, 2), $urandom, won);
    end

    // Wait states on the still-pending data request
    episode(5, $urandom, won);
    while (i_req || d_req) episode($urandom_range(0, 2), $urandom, won);

    // Reset mid-transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_m_req", m_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("midrst_m_req", m_req, 1'b0);
    chk("midrst_m_addr", m_addr, '0);
    chk("midrst_m_we", m_we, 1'b0);
    chk("midrst_acks", {i_ack, d_ack}, 2'b00);
    chk("midrst_rdata", {i_rdata, d_rdata}, '0);
    @(posedge clk); #1;
    m_ready = 1'b1; m_rdata = $urandom;
    @(negedge clk);
    chk("midrst_no_ack", d_ack, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    chk("postrst_no_ack", d_ack, 1'b0);
    chk("postrst_m_req", m_req, 1'b0);
    exp_i_rdata = '0; exp_d_rdata = '0; starve = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
    episode(1, $urandom, won);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end
      if (!i_req && !d_req) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      episode($urandom_range(0, 4), $urandom, won);
    end
    while (i_req || d_req) episode($urandom_range(0, 2), $urandom, won);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog abort on a fetch that never completes
    i_req = 1'b1; i_addr = 32'h500;
    m_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < TMO; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo_busy_m_req", m_req, 1'b1);
      chk("tmo_busy_ack", i_ack, 1'b0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_err", err, 1'b1);
    chk("tmo_i_ack", i_ack, 1'b1);
    chk("tmo_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("tmo_m_req", m_req, 1'b0);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    chk("tmo_err_pulse", err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
